// File: rtl/alu_pkg.sv
// Shared opcode and buffer-state definitions for the ALU responder and its core.
package alu_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational 3-bit-opcode ALU: logic ops, increment/decrement, add/subtract with
// two's complement overflow detection.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       sel,
    output logic [WIDTH-1:0] f,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] ONE_VAL = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        f   = '0;
        ovf = 1'b0;
        case (sel)
            OP_NOT: f = ~a;
            OP_AND: f = a & b;
            OP_XOR: f = a ^ b;
            OP_OR:  f = a | b;
            OP_DEC: begin
                f   = a - ONE_VAL;
                ovf = (a == MIN_VAL);
            end
            OP_ADD: begin
                f   = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                f   = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_INC: begin
                f   = a + ONE_VAL;
                ovf = (a == MAX_VAL);
            end
            default: begin
                f   = '0;
                ovf = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_exec_responder.sv
// Clocked ALU responder: valid/ready request in, in-order results out through a
// 2-entry buffer, plus sticky overflow status and an accepted-op counter.
module alu_exec_responder
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_sel,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_f,
    output logic             resp_ovf,
    output logic [2:0]       resp_sel,
    input  logic             clr_sticky,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] op_count
);

    // Handshake: a request transfers on a rising edge where req_valid & req_ready;
    // a result transfers where resp_valid & resp_ready. Payloads are held while valid
    // is high and the partner is not ready.

    typedef struct packed {
        logic [WIDTH-1:0] f;
        logic             ovf;
        logic [2:0]       sel;
    } entry_t;

    logic [WIDTH-1:0] core_f;
    logic             core_ovf;
    entry_t           new_entry;
    entry_t           head;
    entry_t           tail;
    buf_state_t       state;
    logic             accept;
    logic             pop;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .a   (req_a),
        .b   (req_b),
        .sel (req_sel),
        .f   (core_f),
        .ovf (core_ovf)
    );

    assign new_entry  = '{f: core_f, ovf: core_ovf, sel: req_sel};
    assign accept     = req_valid & req_ready;
    assign resp_valid = (state == ST_ONE) || (state == ST_FULL);
    assign pop        = resp_valid & resp_ready;
    assign resp_f     = head.f;
    assign resp_ovf   = head.ovf;
    assign resp_sel   = head.sel;

    // req_ready is registered from the next occupancy, so it only drops on entering FULL.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            head      <= '0;
            tail      <= '0;
            req_ready <= 1'b0;
        end else begin
            req_ready <= 1'b1;
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        head  <= new_entry;
                        state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    case ({accept, pop})
                        2'b10: begin
                            tail      <= new_entry;
                            state     <= ST_FULL;
                            req_ready <= 1'b0;
                        end
                        2'b01: state <= ST_EMPTY;
                        2'b11: head  <= new_entry;
                        default: state <= ST_ONE;
                    endcase
                end
                ST_FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= ST_ONE;
                    end else begin
                        req_ready <= 1'b0;
                    end
                end
                default: state <= ST_EMPTY;
            endcase
        end
    end

    // Set has priority over clear so an overflow in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
            op_count   <= '0;
        end else begin
            if (accept && core_ovf) begin
                ovf_sticky <= 1'b1;
            end else if (clr_sticky) begin
                ovf_sticky <= 1'b0;
            end
            if (accept) begin
                op_count <= op_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_responder.sv
// Directed bench for alu_exec_responder: opcode vector table plus hand-written
// backpressure, sticky/counter and mid-operation reset sequences.
module tb_alu_exec_responder;

    localparam int WIDTH = 32;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_sel;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_f;
    logic             resp_ovf;
    logic [2:0]       resp_sel;
    logic             clr_sticky;
    logic             ovf_sticky;
    logic [CNT_W-1:0] op_count;

    alu_exec_responder #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_f     (resp_f),
        .resp_ovf   (resp_ovf),
        .resp_sel   (resp_sel),
        .clr_sticky (clr_sticky),
        .ovf_sticky (ovf_sticky),
        .op_count   (op_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: act=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        string       name;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] f;
        logic        ovf;
    } vec_t;

    vec_t             vecs[12];
    logic [WIDTH-1:0] exp_q[$];
    int               n_total;
    int               n_pass;
    logic [CNT_W-1:0] exp_count;
    logic             exp_sticky;
    logic             c_accepted;

    // scoreboard
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: act=%h exp=%h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive_req(input logic [2:0] sel, input logic [31:0] a, input logic [31:0] b);
        req_sel   = sel;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total    = 0;
        n_pass     = 0;
        exp_count  = '0;
        exp_sticky = 1'b0;
        c_accepted = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_sel    = 3'b000;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        clr_sticky = 1'b0;

        vecs[0]  = '{"add_ovf",  3'b101, 32'h7ffffff0, 32'h7fffff00, 32'hfffffef0, 1'b1};
        vecs[1]  = '{"sub_min",  3'b110, 32'h80000000, 32'h00000001, 32'h7fffffff, 1'b1};
        vecs[2]  = '{"dec_min",  3'b100, 32'h80000000, 32'h00000000, 32'h7fffffff, 1'b1};
        vecs[3]  = '{"inc_max",  3'b111, 32'h7fffffff, 32'h00000000, 32'h80000000, 1'b1};
        vecs[4]  = '{"inc_5",    3'b111, 32'h00000005, 32'h00000000, 32'h00000006, 1'b0};
        vecs[5]  = '{"not",      3'b000, 32'hf0f0f0f0, 32'hff00ff00, 32'h0f0f0f0f, 1'b0};
        vecs[6]  = '{"and",      3'b001, 32'hf0f0f0f0, 32'hff00ff00, 32'hf000f000, 1'b0};
        vecs[7]  = '{"xor",      3'b010, 32'hf0f0f0f0, 32'hff00ff00, 32'h0ff00ff0, 1'b0};
        vecs[8]  = '{"or",       3'b011, 32'hf0f0f0f0, 32'hff00ff00, 32'hfff0fff0, 1'b0};
        vecs[9]  = '{"add_neg",  3'b101, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1};
        vecs[10] = '{"sub_neg",  3'b110, 32'h00000005, 32'h00000007, 32'hfffffffe, 1'b0};
        vecs[11] = '{"dec_zero", 3'b100, 32'h00000000, 32'h00000000, 32'hffffffff, 1'b0};

        // reset state
        #12;
        check("rst_req_ready",  {31'd0, req_ready},  32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_f",     resp_f,              32'd0);
        check("rst_resp_ovf",   {31'd0, resp_ovf},   32'd0);
        check("rst_resp_sel",   {29'd0, resp_sel},   32'd0);
        check("rst_sticky",     {31'd0, ovf_sticky}, 32'd0);
        check("rst_count",      {28'd0, op_count},   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", {31'd0, req_ready}, 32'd1);

        // opcode table, one op per cycle with resp_ready held high
        resp_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive_req(vecs[i].sel, vecs[i].a, vecs[i].b);
            check({vecs[i].name, "_ready"}, {31'd0, req_ready}, 32'd1);
            step();
            exp_count  = exp_count + 1'b1;
            exp_sticky = exp_sticky | vecs[i].ovf;
            check({vecs[i].name, "_valid"}, {31'd0, resp_valid}, 32'd1);
            check({vecs[i].name, "_f"},     resp_f,               vecs[i].f);
            check({vecs[i].name, "_ovf"},   {31'd0, resp_ovf},    {31'd0, vecs[i].ovf});
            check({vecs[i].name, "_sel"},   {29'd0, resp_sel},    {29'd0, vecs[i].sel});
            check({vecs[i].name, "_cnt"},   {28'd0, op_count},    {28'd0, exp_count});
            check({vecs[i].name, "_sticky"}, {31'd0, ovf_sticky}, {31'd0, exp_sticky});
        end
        req_valid = 1'b0;
        step();
        check("drain_empty", {31'd0, resp_valid}, 32'd0);

        // backpressure: A and B fill the buffer, C stalls
        resp_ready = 1'b0;
        exp_q.push_back(32'h00000003);
        exp_q.push_back(32'h0000000f);
        exp_q.push_back(32'h00000006);
        drive_req(3'b011, 32'h1, 32'h2);
        step();
        exp_count = exp_count + 1'b1;
        check("bp_a_ready", {31'd0, req_ready}, 32'd1);
        check("bp_a_f",     resp_f,              32'h00000003);
        drive_req(3'b001, 32'hff, 32'h0f);
        step();
        exp_count = exp_count + 1'b1;
        check("bp_full_ready", {31'd0, req_ready}, 32'd0);
        check("bp_hold_f1",    resp_f,              32'h00000003);
        check("bp_hold_sel1",  {29'd0, resp_sel},   32'd3);
        drive_req(3'b010, 32'h5, 32'h3);
        step();
        check("bp_stall_ready", {31'd0, req_ready}, 32'd0);
        check("bp_hold_f2",     resp_f,              32'h00000003);
        check("bp_hold_sel2",   {29'd0, resp_sel},   32'd3);
        check("bp_stall_cnt",   {28'd0, op_count},   {28'd0, exp_count});

        resp_ready = 1'b1;
        for (int cyc = 0; cyc < 10 && exp_q.size() > 0; cyc++) begin
            if (resp_valid) begin
                check("bp_order", resp_f, exp_q.pop_front());
            end
            if (req_valid && req_ready) begin
                c_accepted = 1'b1;
                exp_count  = exp_count + 1'b1;
            end
            step();
            if (c_accepted) req_valid = 1'b0;
        end
        check("bp_drain_done", exp_q.size(), 32'd0);
        check("bp_c_accepted", {31'd0, c_accepted}, 32'd1);
        req_valid = 1'b0;
        step();
        check("bp_empty",  {31'd0, resp_valid}, 32'd0);
        check("bp_count",  {28'd0, op_count},   {28'd0, exp_count});

        // sticky: clear alone, then set-wins, then clear alone
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_clr1", {31'd0, ovf_sticky}, 32'd0);
        drive_req(3'b111, 32'h7fffffff, 32'h0);
        clr_sticky = 1'b1;
        step();
        exp_count  = exp_count + 1'b1;
        req_valid  = 1'b0;
        clr_sticky = 1'b0;
        check("sticky_set_wins", {31'd0, ovf_sticky}, 32'd1);
        check("sticky_resp_ovf", {31'd0, resp_ovf},   32'd1);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky_clr2", {31'd0, ovf_sticky}, 32'd0);
        check("sticky_cnt",  {28'd0, op_count},   {28'd0, exp_count});

        // reset with the buffer full, asserted between edges
        resp_ready = 1'b0;
        drive_req(3'b101, 32'h1, 32'h1);
        step();
        drive_req(3'b101, 32'h2, 32'h2);
        step();
        req_valid = 1'b0;
        check("mid_full", {31'd0, req_ready}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst_cnt",   {28'd0, op_count},   32'd0);
        check("mid_rst_ready", {31'd0, req_ready},  32'd0);
        check("mid_rst_f",     resp_f,              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_count = '0;
        step();
        check("mid_rel_ready", {31'd0, req_ready},  32'd1);
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("mid_no_stale", {31'd0, resp_valid}, 32'd0);
            step();
        end

        // counter wrap with a 4-bit counter
        for (int i = 0; i < 16; i++) begin
            drive_req(3'b111, i, 32'h0);
            step();
            exp_count = exp_count + 1'b1;
            if (i == 14) check("cnt_all_ones", {28'd0, op_count}, 32'd15);
        end
        req_valid = 1'b0;
        check("cnt_wrap", {28'd0, op_count}, 32'd0);
        check("cnt_model", {28'd0, op_count}, {28'd0, exp_count});
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
